// File: rtl/image_rom_scanner_pkg.sv
// Package image_pipe_pkg: shared types and default geometry for the image
// pipeline front end (image_rom_scanner and raster_counter).
//  - state_e  : scanner FSM states
//  - marker_t : per-beat sideband markers {sof, eol, eof}
//  - *_DEF    : default image geometry and word widths
package image_pipe_pkg;
    localparam int IMG_W_DEF  = 256;
    localparam int IMG_H_DEF  = 256;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 17;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } marker_t;
endpackage

// File: rtl/image_rom_scanner_raster_counter.sv
// raster_counter: x/y position and linear ROM address of a raster scan.
// Ports:
//  clk, rst_n       clock, async active-low reset
//  clr_i            return x/y/addr to 0 (has priority over step_i)
//  step_i           advance one pixel; x wraps at IMG_W-1 and bumps y
//  x_o, y_o         current column / line
//  addr_o           current linear address y*IMG_W + x
//  last_col_o       x is the last column of a line
//  last_pix_o       current position is the last pixel of the frame
module raster_counter #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_i,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_col_o,
    output logic              last_pix_o
);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_col_o = (x_q == X_LAST);
    assign last_pix_o = last_col_o && (y_q == Y_LAST);

    // Address is kept as its own incrementing counter rather than y*IMG_W+x.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (step_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_col_o) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/image_rom_scanner.sv
// image_rom_scanner: raster-scan reader for image_rom. Drives a registered ROM
// address, captures the combinational ROM word and emits one frame per start
// as a valid/ready pixel stream with SOF/EOL/EOF markers (1 pixel/clk unstalled).
// Ports:
//  clk, rst_n          clock, async active-low reset
//  start, abort        begin a frame (when idle) / cancel the scan (wins over start)
//  busy, done          scan in progress / 1-clk pulse after the EOF beat is taken
//  rom_addr, rom_data  ROM address out, ROM word in (same cycle)
//  m_valid, m_ready    output stream handshake
//  m_data              pixel word
//  m_sof/m_eol/m_eof   frame start / line end / frame end markers
//  checksum            sum of accepted pixels mod 2**32
// Optional feature: define IMAGE_SCAN_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to 0.
module image_rom_scanner
    import image_pipe_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [31:0]       checksum
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e            state_q, state_d;
    logic              mv_q, mv_d;
    logic [DATA_W-1:0] md_q, md_d;
    marker_t           mk_q, mk_d;
    logic              done_q, done_d;
    logic              load, step, clr, start_acc, beat_acc;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              last_col, last_pix;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .XW    (XW),
        .YW    (YW)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .step_i    (step),
        .x_o       (x),
        .y_o       (y),
        .addr_o    (rom_addr),
        .last_col_o(last_col),
        .last_pix_o(last_pix)
    );

    assign beat_acc  = mv_q && m_ready;
    assign start_acc = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        mv_d    = mv_q;
        md_d    = md_q;
        mk_d    = mk_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                // Output register is free when empty or being drained this cycle.
                load = !mv_q || m_ready;
                if (load) begin
                    mv_d = 1'b1;
                    md_d = rom_data;
                    mk_d = '{sof: (x == '0) && (y == '0), eol: last_col, eof: last_pix};
                    if (last_pix) begin
                        // Address parks at 0 instead of running past the frame.
                        clr     = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Only the EOF beat can be pending here.
                if (beat_acc) begin
                    mv_d    = 1'b0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            mv_d    = 1'b0;
            done_d  = 1'b0;
            step    = 1'b0;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mv_q    <= 1'b0;
            md_q    <= '0;
            mk_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mv_q    <= mv_d;
            md_q    <= md_d;
            mk_q    <= mk_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign m_valid = mv_q;
    assign m_data  = md_q;
    assign m_sof   = mk_q.sof;
    assign m_eol   = mk_q.eol;
    assign m_eof   = mk_q.eof;

`ifdef IMAGE_SCAN_CHECKSUM_EN
    logic [31:0] cs_q, cs_d;

    // Nothing is accepted while idle, so the final sum holds until the next start.
    always_comb begin
        cs_d = cs_q;
        if (start_acc)     cs_d = '0;
        else if (beat_acc) cs_d = cs_q + 32'(md_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_q <= '0;
        else        cs_q <= cs_d;
    end

    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif
endmodule
